wave_trace_reader: RTL and testbench

Display-side reader for the waveform sample buffer. The waveform writer fills a 1024×12-bit dual-port RAM with generator samples. This block reads that RAM in step with the video raster and produces a per-pixel `pixel_flag` that draws the waveform as a connected trace inside a fixed screen window. It also asserts `frame_hold` so the writer freezes the buffer while the window is being scanned, which prevents tearing.

---
 rtl/wave_disp_pkg.sv | 11 +
 rtl/wave_scale.sv | 22 ++
 rtl/wave_trace_reader.sv | 88 ++++++++
 tb/tb_wave_trace_reader.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/wave_disp_pkg.sv
// wave_disp_pkg: shared widths, default trace-window geometry and hold-state type
// for the waveform display read path.
package wave_disp_pkg;
    localparam int SAMPLE_W  = 12;
    localparam int ADDR_W    = 10;
    localparam int X0_DEF    = 128;
    localparam int Y0_DEF    = 60;
    localparam int WIN_W_DEF = 1024;
    localparam int SHIFT_DEF = 3;
    typedef enum logic {IDLE, HOLD} hold_state_e;
endpackage

// File: rtl/wave_scale.sv
// wave_scale: registered sample-to-screen-row conversion; large samples map to
// rows near the top of the window.
module wave_scale
    import wave_disp_pkg::*;
#(
    parameter int Y0    = Y0_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    output logic [10:0]         row_o
);
    localparam logic [10:0] Y_BOT = 11'(Y0 + 2**(SAMPLE_W-SHIFT) - 1);
    logic [10:0] row_q, row_d;
    assign row_d = Y_BOT - 11'(sample_i >> SHIFT);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) row_q <= '0;
        else if (en_i) row_q <= row_d;
    assign row_o = row_q;
endmodule

// File: rtl/wave_trace_reader.sv
// wave_trace_reader: reads the sample RAM two columns ahead of the raster, draws a
// connected trace flag and holds off the writer while the window is scanned.
module wave_trace_reader
    import wave_disp_pkg::*;
#(
    parameter int X0    = X0_DEF,
    parameter int Y0    = Y0_DEF,
    parameter int WIN_W = WIN_W_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [10:0]         pixel_xpos,
    input  logic [10:0]         pixel_ypos,
    input  logic [SAMPLE_W-1:0] ram_rd_data,
    output logic                ram_rd_en,
    output logic [ADDR_W-1:0]   ram_rd_addr,
    output logic                pixel_flag,
    output logic                frame_hold
);
    localparam int H = 2**(SAMPLE_W-SHIFT);
    localparam logic [10:0] Y_LO  = 11'(Y0);
    localparam logic [10:0] Y_END = 11'(Y0 + H);
    localparam logic [10:0] Y_PRE = 11'(Y0 - 1);
    localparam logic signed [11:0] C_X0  = 12'(X0);
    localparam logic signed [11:0] C_MIN = -12'sd2;
    localparam logic signed [11:0] C_MAX = 12'(WIN_W - 3);
    localparam logic signed [11:0] C_W   = 12'(WIN_W);

    logic signed [11:0] col;
    logic in_y, in_x, issue, flag_d;
    logic [ADDR_W-1:0] addr_q;
    logic vld_q, fst_q, lnk_q, arm_q, flag_q;
    logic [10:0] y_cur, y_prev_q, y_p, y_lo, y_hi;
    hold_state_e st_q, st_d;

    assign col   = $signed({1'b0, pixel_xpos}) - C_X0;
    assign in_y  = pixel_ypos >= Y_LO && pixel_ypos < Y_END;
    assign in_x  = !col[11] && col < C_W;
    // gated by rst_n so the read port is idle while reset is held
    assign issue = rst_n && in_y && col >= C_MIN && col <= C_MAX;

    assign ram_rd_en   = issue;
    assign ram_rd_addr = issue ? ADDR_W'(col + 12'sd2) : addr_q;

    wave_scale #(.Y0(Y0), .SHIFT(SHIFT)) u_scale (
        .clk(clk), .rst_n(rst_n), .en_i(vld_q), .sample_i(ram_rd_data), .row_o(y_cur)
    );

    // column 0 is unlinked: the segment collapses onto its own row
    assign y_p  = lnk_q ? y_prev_q : y_cur;
    assign y_lo = y_p < y_cur ? y_p : y_cur;
    assign y_hi = y_p < y_cur ? y_cur : y_p;

    always_comb begin
        flag_d = arm_q && in_y && in_x && pixel_ypos >= y_lo && pixel_ypos <= y_hi;
        st_d   = st_q;
        if (st_q == IDLE) st_d = (pixel_xpos == '0 && pixel_ypos == Y_PRE) ? HOLD : IDLE;
        else st_d = ((pixel_xpos == '0 && pixel_ypos == Y_END) || pixel_ypos < Y_PRE) ? IDLE : HOLD;
    end

    // arm_q keeps the flag off after reset until a column-0 sample has landed
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            addr_q   <= '0;
            vld_q    <= 1'b0;
            fst_q    <= 1'b0;
            lnk_q    <= 1'b0;
            arm_q    <= 1'b0;
            y_prev_q <= '0;
            flag_q   <= 1'b0;
            st_q     <= IDLE;
        end else begin
            if (issue) addr_q <= ram_rd_addr;
            vld_q <= issue;
            fst_q <= issue && col == C_MIN;
            if (vld_q) begin
                y_prev_q <= y_cur;
                lnk_q    <= !fst_q;
                arm_q    <= arm_q || fst_q;
            end
            flag_q <= flag_d;
            st_q   <= st_d;
        end

    assign pixel_flag = flag_q;
    assign frame_hold = st_q == HOLD;
endmodule

// File: tb/tb_wave_trace_reader.sv
// tb_wave_trace_reader: directed vectors against a behavioural sample RAM.
module tb_wave_trace_reader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] pixel_xpos, pixel_ypos;
    logic [11:0] ram_rd_data = '0;
    logic        ram_rd_en, pixel_flag, frame_hold;
    logic [9:0]  ram_rd_addr;

    wave_trace_reader dut (
        .clk(clk), .rst_n(rst_n), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
        .ram_rd_data(ram_rd_data), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
        .pixel_flag(pixel_flag), .frame_hold(frame_hold)
    );

    always #5 clk = ~clk;

    logic [11:0] mem [1024];
    always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];

    typedef struct {
        int pat; int y; int x; bit en; int addr; bit fl;
    } vec_t;
    vec_t tbl[$];

    int n_cmp = 0, n_bad = 0;
    bit en_s, fl_s, hd_s;
    int addr_s;
    bit fl_a [1200];
    bit en_a [1200];
    int ad_a [1200];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Present one coordinate: read-issue outputs sampled before the edge,
    // registered flag/hold sampled just after it.
    task automatic present(input int x, input int y);
        pixel_xpos = 11'(x);
        pixel_ypos = 11'(y);
        #1;
        en_s = ram_rd_en;
        addr_s = int'(ram_rd_addr);
        @(posedge clk);
        #1;
        fl_s = pixel_flag;
        hd_s = frame_hold;
    endtask

    task automatic scan(input int y);
        for (int x = 0; x < 1200; x++) begin
            present(x, y);
            fl_a[x] = fl_s;
            en_a[x] = en_s;
            ad_a[x] = addr_s;
        end
    endtask

    task automatic fill(input int pat);
        for (int a = 0; a < 1024; a++)
            mem[a] = pat == 0 ? 12'(a * 4) : pat == 1 ? (a < 100 ? 12'h000 : 12'hFFF) : 12'h800;
    endtask

    task automatic add(input int pat, input int y, input int x, input bit en, input int addr, input bit fl);
        tbl.push_back('{pat, y, x, en, addr, fl});
    endtask

    initial begin
        int cur_pat, cur_y;
        rst_n = 1'b0;
        pixel_xpos = '0;
        pixel_ypos = '0;
        fill(2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset flag", pixel_flag, 0);
        chk("reset rd_en", ram_rd_en, 0);
        chk("reset rd_addr", ram_rd_addr, 0);
        chk("reset hold", frame_hold, 0);
        rst_n = 1'b1;

        // constant mid-scale sample: trace is a single horizontal line at Y0+255
        for (int y = 314; y <= 316; y++) begin
            scan(y);
            for (int x = 0; x < 1200; x++)
                chk($sformatf("const y=%0d x=%0d flag", y, x), fl_a[x], (y == 315 && x >= 128 && x < 1152) ? 1 : 0);
        end

        // ramp RAM[a]=4a: row r(c) = 571 - (c>>1)
        add(0, 70, 125, 0, 0, 0);     add(0, 70, 126, 1, 0, 0);
        add(0, 70, 127, 1, 1, 0);     add(0, 70, 128, 1, 2, 0);
        add(0, 70, 1129, 1, 1003, 0); add(0, 70, 1130, 1, 1004, 1);
        add(0, 70, 1131, 1, 1005, 1); add(0, 70, 1132, 1, 1006, 1);
        add(0, 70, 1133, 1, 1007, 0); add(0, 70, 1149, 1, 1023, 0);
        add(0, 70, 1150, 0, 0, 0);
        add(0, 571, 127, 1, 1, 0);    add(0, 571, 128, 1, 2, 1);
        add(0, 571, 130, 1, 4, 1);    add(0, 571, 131, 1, 5, 0);
        add(0, 60, 128, 1, 2, 0);     add(0, 60, 1151, 0, 0, 1);
        add(0, 60, 1152, 0, 0, 0);
        add(0, 572, 126, 0, 0, 0);    add(0, 572, 600, 0, 0, 0);
        add(0, 59, 600, 0, 0, 0);
        // step 0x000 -> 0xFFF between addresses 99 and 100
        add(1, 60, 228, 1, 102, 1);   add(1, 60, 229, 1, 103, 1);
        add(1, 60, 1151, 0, 0, 1);
        add(1, 300, 228, 1, 102, 1);  add(1, 300, 227, 1, 101, 0);
        add(1, 300, 229, 1, 103, 0);  add(1, 300, 128, 1, 2, 0);
        add(1, 571, 228, 1, 102, 1);  add(1, 571, 227, 1, 101, 1);
        add(1, 571, 128, 1, 2, 1);

        cur_pat = -1;
        cur_y = -1;
        foreach (tbl[i]) begin
            if (tbl[i].pat != cur_pat) begin
                fill(tbl[i].pat);
                cur_pat = tbl[i].pat;
                cur_y = -1;
            end
            if (tbl[i].y != cur_y) begin
                scan(tbl[i].y);
                cur_y = tbl[i].y;
            end
            chk($sformatf("vec%0d rd_en", i), en_a[tbl[i].x], tbl[i].en);
            if (tbl[i].en) chk($sformatf("vec%0d rd_addr", i), ad_a[tbl[i].x], tbl[i].addr);
            chk($sformatf("vec%0d flag", i), fl_a[tbl[i].x], tbl[i].fl);
        end

        // hold window over a raster of short lines
        for (int y = 0; y < 600; y++)
            for (int x = 0; x < 4; x++) begin
                present(x, y);
                chk($sformatf("hold y=%0d x=%0d", y, x), hd_s, (y >= 59 && y <= 571) ? 1 : 0);
            end
        present(0, 20);  chk("hold idle", hd_s, 0);
        present(1, 59);  chk("hold needs x0", hd_s, 0);
        present(0, 59);  chk("hold enter", hd_s, 1);
        present(5, 300); chk("hold stay", hd_s, 1);
        present(0, 10);  chk("hold restart", hd_s, 0);

        // reset mid-line
        fill(2);
        for (int x = 0; x <= 428; x++) present(x, 315);
        chk("pre-reset flag", fl_s, 1);
        rst_n = 1'b0;
        #1;
        chk("rst flag", pixel_flag, 0);
        chk("rst rd_en", ram_rd_en, 0);
        chk("rst rd_addr", ram_rd_addr, 0);
        chk("rst hold", frame_hold, 0);
        present(429, 315); chk("rst flag held", fl_s, 0);
        present(430, 315); chk("rst flag held2", fl_s, 0);
        rst_n = 1'b1;
        for (int x = 431; x < 1200; x++) begin
            present(x, 315);
            chk($sformatf("post-rst x=%0d flag", x), fl_s, 0);
        end
        scan(315);
        chk("next line col0 flag", fl_a[128], 1);
        chk("next line mid flag", fl_a[600], 1);
        chk("next line last flag", fl_a[1151], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
